parity_check_arbiter: RTL

- Round-robin controller that shares one registered 8-bit parity-check datapath between NREQ requesters.
- Each requester presents a byte, a received parity bit and an odd/even select. The block grants one requester, checks its byte, and returns a tagged match/mismatch result over a valid/ready handshake.
- Keeps a saturating mismatch counter for link-health monitoring.
- Sits between the byte-stream receivers and the status/CSR logic.

---
 rtl/parity_check_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit parity checker between NREQ
// requesters; returns a tagged match/mismatch result and a saturating error count.
module parity_check_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_pin,
    input  logic [NREQ-1:0]   req_oe,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDW-1:0]    res_id,
    output logic              res_match,
    output logic              res_mismatch,
    input  logic              clr_count,
    output logic [CNTW-1:0]   err_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

    // oe=1 selects even parity, oe=0 odd parity
    function automatic logic parity_ok(input logic [7:0] d, input logic pin, input logic oe);
        logic pgen;
        pgen = parity8(d);
        return oe ? (pin == pgen) : (pin == ~pgen);
    endfunction

    state_t          state_r, next_s;
    logic [IDW-1:0]  rr_last_r;
    logic [7:0]      data_r;
    logic            pin_r, oe_r;
    logic            res_valid_r, res_match_r, res_mismatch_r;
    logic [IDW-1:0]  res_id_r;
    logic [CNTW-1:0] err_count_r;

    logic [IDW-1:0]  grant_id_s, idx_s;
    logic            grant_found_s, accept_s, handshake_s;
    logic [7:0]      sel_data_s;
    logic            sel_pin_s, sel_oe_s;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        idx_s         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = IDW'((int'(rr_last_r) + k) % NREQ);
            if (!grant_found_s && req_valid[idx_s]) begin
                grant_found_s = 1'b1;
                grant_id_s    = idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Route the granted requester's byte, parity bit and mode
    always_comb begin
        sel_data_s = 8'h00;
        sel_pin_s  = 1'b0;
        sel_oe_s   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_s == IDW'(i)) begin
                sel_data_s = req_data[8*i +: 8];
                sel_pin_s  = req_pin[i];
                sel_oe_s   = req_oe[i];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next-state logic and grant strobe
    always_comb begin
        next_s      = state_r;
        accept_s    = 1'b0;
        handshake_s = 1'b0;
        req_ready   = '0;
        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    req_ready[grant_id_s] = 1'b1;
                    accept_s              = 1'b1;
                    next_s                = CHECK;
                end else begin
                    next_s = IDLE;
                end
            end
            CHECK: next_s = RESP;
            RESP: begin
                if (res_valid_r && res_ready) begin
                    handshake_s = 1'b1;
                    next_s      = IDLE;
                end else begin
                    next_s = RESP;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Request capture, check and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_r      <= IDW'(NREQ - 1);
            data_r         <= 8'h00;
            pin_r          <= 1'b0;
            oe_r           <= 1'b0;
            res_valid_r    <= 1'b0;
            res_match_r    <= 1'b0;
            res_mismatch_r <= 1'b0;
            res_id_r       <= '0;
        end else begin
            if (accept_s) begin
                rr_last_r <= grant_id_s;
                data_r    <= sel_data_s;
                pin_r     <= sel_pin_s;
                oe_r      <= sel_oe_s;
            end else if (state_r == CHECK) begin
                res_match_r    <= parity_ok(data_r, pin_r, oe_r);
                res_mismatch_r <= ~parity_ok(data_r, pin_r, oe_r);
                res_id_r       <= rr_last_r;
                res_valid_r    <= 1'b1;
            end else if (handshake_s) begin
                res_valid_r <= 1'b0;
            end else begin
                res_valid_r <= res_valid_r;
            end
        end
    end

    // Saturating mismatch counter; clear has priority over a counted mismatch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_r <= '0;
        end else if (clr_count) begin
            err_count_r <= '0;
        end else if (handshake_s && res_mismatch_r && (err_count_r != {CNTW{1'b1}})) begin
            err_count_r <= err_count_r + CNTW'(1);
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign res_valid    = res_valid_r;
    assign res_id       = res_id_r;
    assign res_match    = res_match_r;
    assign res_mismatch = res_mismatch_r;
    assign err_count    = err_count_r;
    assign busy         = (state_r != IDLE);

endmodule
